// File: rtl/conv_window_gen_if.sv
// Handshake bundle for the 3x3 window generator: pixel stream in, window stream out.
// master = upstream producer / downstream consumer side, slave = the window generator.
interface conv_window_gen_if #(
    parameter int DATA_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [9*DATA_W-1:0]   out_win;
    logic                  out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_win, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_win, out_last
    );
endinterface

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator. One pixel per cycle in raster order, two line
// buffers plus a 3x3 shift window, one registered output stage with valid/ready.
//
// Phase FSM (derived from the row counter):
//   state  | meaning
//   FILL   | rows 0/1 of the frame, line buffers filling, no windows emitted
//   ACTIVE | rows 2..IMG_H-1, windows emitted once col >= 2
module conv_window_gen #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input logic              clk,
    input logic              reset,
    conv_window_gen_if.slave bus
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [0:0] FILL   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [RW-1:0]         row_nxt;
    logic [0:0]            phase;

    logic [DATA_W-1:0]     lb0 [IMG_W];
    logic [DATA_W-1:0]     lb1 [IMG_W];

    logic [DATA_W-1:0]     win  [3][3];
    logic [DATA_W-1:0]     nwin [3][3];
    logic [9*DATA_W-1:0]   win_flat;

    logic                  out_valid_q;
    logic [9*DATA_W-1:0]   out_win_q;
    logic                  out_last_q;

    logic                  in_ready_w;
    logic                  accept;
    logic                  col_last;
    logic                  row_last;
    logic                  emit;

    assign in_ready_w    = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && in_ready_w;
    assign col_last      = (col == CW'(IMG_W - 1));
    assign row_last      = (row == RW'(IMG_H - 1));
    assign row_nxt       = row_last ? '0 : row + RW'(1);
    assign emit          = accept && (phase == ACTIVE) && (col >= CW'(2));

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_win   = out_win_q;
    assign bus.out_last  = out_last_q;

    // Window after this cycle's shift: columns move left, new column comes from LB1/LB0/input.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) begin
                nwin[i][j] = win[i][j+1];
            end
        end
        nwin[0][2] = lb1[col];
        nwin[1][2] = lb0[col];
        nwin[2][2] = bus.in_data;
    end

    // Flatten the shifted window: byte k = 3*row_offset + col_offset, newest pixel at k=8.
    always_comb begin
        win_flat = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_flat[DATA_W*(3*i+j) +: DATA_W] = nwin[i][j];
            end
        end
    end

    // Position counters and phase; a frame wrap goes straight back to FILL with no idle cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            col   <= '0;
            row   <= '0;
            phase <= FILL;
        end else if (accept) begin
            if (col_last) begin
                col   <= '0;
                row   <= row_nxt;
                phase <= (row_nxt >= RW'(2)) ? ACTIVE : FILL;
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers need no reset: every entry is rewritten before it can reach an emitted window.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= bus.in_data;
        end
    end

    // 3x3 shift window, advanced on every accepted pixel.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (accept) begin
            win <= nwin;
        end
    end

    // Single output stage: load on an emitting accept, otherwise clear once consumed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_win_q   <= '0;
            out_last_q  <= 1'b0;
        end else if (emit) begin
            out_valid_q <= 1'b1;
            out_win_q   <= win_flat;
            out_last_q  <= row_last && col_last;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 window generator for the convolution datapath. Accepts one pixel per cycle in raster order, keeps two line buffers and a 3x3 shift window, and presents each complete 3x3 neighbourhood as a 72-bit word (default width). It feeds the 144-bit operand pipeline register, which concatenates this window with the 9 matching weights. Valid/ready handshakes on both sides support stalls from the MAC array.

## Interface
- DATA_W, 8, pixel width in bits
- IMG_W, 8, pixels per row (>=3)
- IMG_H, 8, rows per frame (>=3)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- in_valid  in  1  in_data holds a valid pixel
- in_ready  out  1  block accepts a pixel this cycle
- in_data  in  DATA_W  pixel, raster order, row 0 col 0 first
- out_valid  out  1  out_win/out_last hold a valid window
- out_ready  in  1  downstream consumes the window this cycle
- out_win  out  9*DATA_W  window; byte k = 3*i+j at [DATA_W*k +: DATA_W], i = row offset (0 = row r-2), j = column offset (0 = col c-2); k=8 is the newest pixel
- out_last  out  1  window is the last of the frame (pixel at row IMG_H-1, col IMG_W-1)

## Operation
- Accept = in_valid && in_ready. in_ready = !out_valid || out_ready (single output stage, no bubble under full throughput).
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the next pixel. On accept: col increments; at IMG_W-1 col wraps to 0 and row increments; at (IMG_H-1, IMG_W-1) both wrap to 0 (next frame, no idle cycle needed).
- Two line buffers LB0 (row r-1) and LB1 (row r-2), IMG_W entries each, indexed by col. On accept at col c: read LB1[c], LB0[c]; write LB1[c] <= LB0[c], LB0[c] <= in_data.
- Window shift register: 3 rows x 3 columns. On accept, each row shifts one column left; new column = {LB1[c], LB0[c], in_data}.
- Phase FSM, derived from row: FILL (row < 2, no output) -> ACTIVE (row >= 2). Frame wrap returns to FILL.
- A window is emitted on accept when row >= 2 and col >= 2. out_win is loaded with the shifted window including the new column; out_last = (row == IMG_H-1 && col == IMG_W-1).
- Columns from the previous row remaining in the shift register at col 0/1 are never emitted (col >= 2 gate).
- Windows per frame = (IMG_W-2)*(IMG_H-2).
- Line buffer contents need no reset: they are written before being read into any emitted window.

## Timing
- Reset (reset == 0 at a rising edge): out_valid = 0, out_win = 0, out_last = 0, row = col = 0, window register = 0. in_ready = 1 on the first cycle after reset.
- Latency: the window appears on out_valid the cycle after the accept of its newest pixel.
- out_valid rises on an emitting accept. It stays high with out_win/out_last stable until a cycle with out_ready = 1. In that cycle a new emitting accept reloads the output, otherwise out_valid falls.
- out_valid = 1 and out_ready = 0: in_ready = 0, no accept, counters and buffers frozen.
- in_valid low: nothing changes. A pending output is still drained by out_ready.
- Reset mid-frame overrides everything. A pending window is dropped, and the next accepted pixel is (0,0).
- Throughput: 1 pixel/cycle when in_valid and out_ready are held high.

## Test plan
- IMG_W=IMG_H=4, pixel = 4*r+c, in_valid=out_ready=1 continuously -> exactly 4 windows. The first appears the cycle after pixel 10 with bytes k0..k8 = 0,1,2,4,5,6,8,9,10. The next three windows are 1,2,3,5,6,7,9,10,11; 4,5,6,8,9,10,12,13,14; and 5,6,7,9,10,11,13,14,15, the last with out_last=1.
- Same stream, out_ready held 0 for 5 cycles after the first window -> out_win stays at 0,1,2,4,5,6,8,9,10, and in_ready=0 for those 5 cycles. On release, the second window (ending at 11) follows with no loss or duplication.
- Two frames back-to-back, second frame pixel = 100+4*r+c -> the first window of frame 2 is 100,101,102,104,105,106,108,109,110. No frame-1 data leaks into it.
- Random in_valid gaps (~50% duty) -> window sequence identical to the gap-free case. out_valid never asserts during row 0/1 or col 0/1.
- reset low for 1 cycle after pixel 9 of frame 1 -> out_valid=0, out_win=0. A fresh frame then produces the first-scenario windows exactly.
- DATA_W=8, all pixels 255 -> out_win = all ones (72 bits) for every window. No width truncation.
